// File: rtl/line_fill_unit_if.sv
// Cache-side request/response and system-bus signal bundle for line_fill_unit.
// slave = the unit's view, master = the cache/bus environment's view.
interface line_fill_unit_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BYTES     = 64
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [LINE_BYTES*8-1:0]   req_wdata;
    logic                      resp_valid;
    logic                      resp_write;
    logic [ADDR_WIDTH-1:0]     resp_addr;
    logic [LINE_BYTES*8-1:0]   resp_line;
    logic                      resp_err;
    logic                      busy;
    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output req_ready, resp_valid, resp_write, resp_addr,
        output resp_line, resp_err, busy,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  req_ready, resp_valid, resp_write, resp_addr,
        input  resp_line, resp_err, busy,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/line_fill_unit.sv
// Line fill / write-back engine between the L1 cache and the system bus.
// Optional FILL_TIMEOUT_EN aborts a transaction stalled in ADDR or RDATA.
module line_fill_unit #(
    parameter int ADDR_WIDTH     = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BYTES     = 64,
    parameter logic [BUS_TAG_WIDTH-1:0] TAG_READ  = 'h1100,
    parameter logic [BUS_TAG_WIDTH-1:0] TAG_WRITE = 'h0100,
    parameter int TIMEOUT        = 1024
) (
    input logic        clk,
    input logic        reset,
    line_fill_unit_if.slave lf
);
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int BEATS  = LINE_W / BUS_DATA_WIDTH;
    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int CW     = $clog2(BEATS);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_inc;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [ADDR_WIDTH-1:0]     aligned;
    logic                      write_q;
    logic [LINE_W-1:0]         wdata_q;
    logic [LINE_W-1:0]         fill_q;
    logic [LINE_W-1:0]         fill_next;
    logic [LINE_W-1:0]         line_q;
    logic [ADDR_WIDTH-1:0]     resp_addr_q;
    logic                      resp_write_q;
    logic                      resp_valid_q;
    logic                      resp_err_q;
    logic                      reqcyc_q;
    logic [BUS_DATA_WIDTH-1:0] req_q;
    logic [BUS_TAG_WIDTH-1:0]  tag_q;
    logic                      respack;
    logic                      expired;

    assign aligned = {lf.req_addr[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign cnt_inc = cnt + CW'(1);
    assign respack = (state == RDATA) && lf.bus_respcyc
                     && (lf.bus_resptag == TAG_READ);

    always_comb begin
        fill_next = fill_q;
        fill_next[BUS_DATA_WIDTH*cnt +: BUS_DATA_WIDTH] = lf.bus_resp;
    end

`ifdef FILL_TIMEOUT_EN
    logic [15:0] timer;

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= '0;
        end else if ((state == IDLE && lf.req_valid)
                     || (state == ADDR && lf.bus_reqack)
                     || respack) begin
            timer <= '0;
        end else if (state == ADDR || state == RDATA) begin
            timer <= timer + 16'd1;
        end else begin
            timer <= '0;
        end
    end

    // Fires on the edge where the stall count would reach TIMEOUT.
    assign expired = ((state == ADDR && !lf.bus_reqack)
                      || (state == RDATA && !respack))
                     && (timer == 16'(TIMEOUT - 1));
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            fill_q       <= '0;
            line_q       <= '0;
            resp_addr_q  <= '0;
            resp_write_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            reqcyc_q     <= 1'b0;
            req_q        <= '0;
            tag_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (lf.req_valid) begin
                        addr_q   <= aligned;
                        write_q  <= lf.req_write;
                        wdata_q  <= lf.req_wdata;
                        cnt      <= '0;
                        reqcyc_q <= 1'b1;
                        req_q    <= BUS_DATA_WIDTH'(aligned);
                        tag_q    <= lf.req_write ? TAG_WRITE : TAG_READ;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (lf.bus_reqack) begin
                        cnt <= '0;
                        if (write_q) begin
                            req_q <= wdata_q[BUS_DATA_WIDTH-1:0];
                            tag_q <= TAG_WRITE;
                            state <= WDATA;
                        end else begin
                            reqcyc_q <= 1'b0;
                            req_q    <= '0;
                            tag_q    <= '0;
                            state    <= RDATA;
                        end
                    end
                end
                WDATA: begin
                    cnt <= cnt_inc;
                    if (cnt == LAST) begin
                        reqcyc_q     <= 1'b0;
                        req_q        <= '0;
                        tag_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_addr_q  <= addr_q;
                        resp_write_q <= 1'b1;
                        state        <= DONE;
                    end else begin
                        req_q <= wdata_q[BUS_DATA_WIDTH*cnt_inc +: BUS_DATA_WIDTH];
                    end
                end
                RDATA: begin
                    if (respack) begin
                        fill_q <= fill_next;
                        cnt    <= cnt_inc;
                        if (cnt == LAST) begin
                            line_q       <= fill_next;
                            resp_valid_q <= 1'b1;
                            resp_addr_q  <= addr_q;
                            resp_write_q <= 1'b0;
                            state        <= DONE;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (expired) begin
                state      <= IDLE;
                cnt        <= '0;
                reqcyc_q   <= 1'b0;
                req_q      <= '0;
                tag_q      <= '0;
                resp_err_q <= 1'b1;
            end
        end
    end

    assign lf.req_ready   = (state == IDLE);
    assign lf.busy        = (state != IDLE);
    assign lf.resp_valid  = resp_valid_q;
    assign lf.resp_write  = resp_write_q;
    assign lf.resp_addr   = resp_addr_q;
    assign lf.resp_line   = line_q;
    assign lf.resp_err    = resp_err_q;
    assign lf.bus_reqcyc  = reqcyc_q;
    assign lf.bus_req     = req_q;
    assign lf.bus_reqtag  = tag_q;
    assign lf.bus_respack = respack;
endmodule

// File: tb/tb_line_fill_unit.sv
// Scoreboard bench for line_fill_unit: directed fills, write-backs,
// beat gaps, stray tags, mid-transaction reset and back-to-back requests.
module tb_line_fill_unit;
    localparam logic [12:0] TR = 13'h1100;
    localparam logic [12:0] TW = 13'h0100;
`ifdef FILL_TIMEOUT_EN
    localparam int TMO = 16;
    localparam int EXP_ERR = 1;
`else
    localparam int TMO = 1024;
    localparam int EXP_ERR = 0;
`endif

    typedef struct {
        logic         w;
        logic [63:0]  a;
        logic [511:0] line;
        int           cyc;
    } resp_t;

    typedef struct {
        logic [63:0] d;
        logic [12:0] tag;
        logic        is_addr;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   err_seen = 0;
    resp_t sb[$];
    beat_t bq[$];
    logic [511:0] last_rd = '0;

    line_fill_unit_if lf();

    line_fill_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .lf(lf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[64*i +: 64] = base + 64'(i);
        return l;
    endfunction

    // Monitor: compares every response and every request-side bus beat.
    always @(negedge clk) begin
        if (reset) begin
            if (lf.resp_valid) begin
                if (sb.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    resp_t e;
                    e = sb.pop_front();
                    chk("resp_write", lf.resp_write, e.w);
                    chk("resp_addr", lf.resp_addr, e.a);
                    chk("resp_line", lf.resp_line, e.line);
                    if (e.cyc >= 0) chk("resp_latency", cyc, e.cyc);
                end
            end
            if (lf.bus_reqcyc) begin
                if (bq.size() == 0) begin
                    chk("bus_beat_unexpected", 1, 0);
                end else begin
                    chk("bus_req", lf.bus_req, bq[0].d);
                    chk("bus_reqtag", lf.bus_reqtag, bq[0].tag);
                    if (!bq[0].is_addr || lf.bus_reqack) void'(bq.pop_front());
                end
            end
            if (lf.resp_err) err_seen++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic w, input logic [63:0] a,
                               input logic [511:0] line, input int lat);
        resp_t e;
        e.w = w;
        e.a = a;
        e.line = line;
        e.cyc = (lat < 0) ? -1 : cyc + lat;
        sb.push_back(e);
    endtask

    task automatic start_req(input logic w, input logic [63:0] a,
                             input logic [511:0] wd, input logic hold);
        beat_t b;
        b.d = a & ~64'h3f;
        b.tag = w ? TW : TR;
        b.is_addr = 1'b1;
        bq.push_back(b);
        if (w) begin
            for (int i = 0; i < 8; i++) begin
                b.d = wd[64*i +: 64];
                b.tag = TW;
                b.is_addr = 1'b0;
                bq.push_back(b);
            end
        end
        lf.req_valid = 1'b1;
        lf.req_write = w;
        lf.req_addr = a;
        lf.req_wdata = wd;
        tick();
        if (!hold) lf.req_valid = 1'b0;
    endtask

    task automatic ack(input int delay);
        repeat (delay) tick();
        lf.bus_reqack = 1'b1;
        tick();
        lf.bus_reqack = 1'b0;
    endtask

    task automatic beats(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            lf.bus_respcyc = 1'b1;
            lf.bus_resp = base + 64'(i);
            lf.bus_resptag = TR;
            #1;
            chk("respack_on_beat", lf.bus_respack, 1);
            tick();
        end
        lf.bus_respcyc = 1'b0;
    endtask

    task automatic wait_idle;
        int k = 0;
        while (!lf.req_ready && k < 50) begin
            tick();
            k++;
        end
        chk("idle_wait", lf.req_ready, 1);
    endtask

    initial begin
        int bc[8] = '{2, 5, 6, 9, 10, 11, 14, 15};
        int idx;
        lf.req_valid = 0;
        lf.req_write = 0;
        lf.req_addr = '0;
        lf.req_wdata = '0;
        lf.bus_reqack = 0;
        lf.bus_respcyc = 0;
        lf.bus_resp = '0;
        lf.bus_resptag = '0;
        repeat (3) tick();
        reset = 1'b1;
        chk("rst_req_ready", lf.req_ready, 1);
        chk("rst_busy", lf.busy, 0);
        chk("rst_resp_valid", lf.resp_valid, 0);
        chk("rst_resp_line", lf.resp_line, 0);
        chk("rst_bus_reqcyc", lf.bus_reqcyc, 0);
        tick();

        // Plain fill with immediate ack and back-to-back beats.
        expect_resp(0, 64'h1040, mk(0), 10);
        start_req(0, 64'h1043, '0, 0);
        chk("busy_in_addr", lf.busy, 1);
        ack(0);
        beats(0, 8);
        last_rd = mk(0);
        wait_idle();

        // Write-back with a 3-cycle ack stall.
        expect_resp(1, 64'h2000, last_rd, 13);
        start_req(1, 64'h2000, mk(64'hA0), 0);
        ack(3);
        wait_idle();

        // Fill with gaps and one wrongly tagged beat.
        expect_resp(0, 64'h5000, mk(64'h30), 16);
        start_req(0, 64'h5000, '0, 0);
        ack(0);
        idx = 0;
        for (int k = 2; k <= 15; k++) begin
            if (idx < 8 && bc[idx] == k) begin
                lf.bus_respcyc = 1;
                lf.bus_resp = 64'h30 + 64'(idx);
                lf.bus_resptag = TR;
                #1;
                chk("gap_respack", lf.bus_respack, 1);
                idx++;
            end else if (k == 7) begin
                lf.bus_respcyc = 1;
                lf.bus_resp = 64'hDEAD;
                lf.bus_resptag = TW;
                #1;
                chk("stray_respack", lf.bus_respack, 0);
            end else begin
                lf.bus_respcyc = 0;
            end
            tick();
        end
        lf.bus_respcyc = 0;
        last_rd = mk(64'h30);
        wait_idle();

        // Reset after four beats of a fill.
        start_req(0, 64'h4000, '0, 0);
        ack(0);
        beats(64'h90, 4);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        last_rd = '0;
        chk("mid_rst_ready", lf.req_ready, 1);
        chk("mid_rst_line", lf.resp_line, 0);
        lf.bus_respcyc = 1;
        lf.bus_resptag = TR;
        lf.bus_resp = 64'h77;
        #1;
        chk("mid_rst_respack", lf.bus_respack, 0);
        lf.bus_respcyc = 0;
        tick();
        expect_resp(0, 64'h4000, mk(64'h50), 10);
        start_req(0, 64'h4000, '0, 0);
        ack(0);
        beats(64'h50, 8);
        last_rd = mk(64'h50);
        wait_idle();

        // req_valid held high across two transactions.
        expect_resp(0, 64'h3000, mk(64'h70), 10);
        start_req(0, 64'h3000, '0, 1);
        ack(0);
        beats(64'h70, 8);
        last_rd = mk(64'h70);
        chk("done_not_ready", lf.req_ready, 0);
        lf.req_write = 1;
        lf.req_addr = 64'h3040;
        lf.req_wdata = mk(64'hB0);
        tick();
        chk("idle_after_done", lf.req_ready, 1);
        expect_resp(1, 64'h3040, last_rd, 10);
        start_req(1, 64'h3040, mk(64'hB0), 0);
        ack(0);
        wait_idle();

`ifdef FILL_TIMEOUT_EN
        begin
            int k = 0;
            start_req(0, 64'h6000, '0, 0);
            while (!lf.resp_err && k < 40) begin
                tick();
                k++;
            end
            chk("timeout_cycles", k, 16);
            tick();
            chk("timeout_ready", lf.req_ready, 1);
            if (bq.size() > 0) void'(bq.pop_front());
        end
`endif

        repeat (3) tick();
        chk("err_pulses", err_seen, EXP_ERR);
        chk("sb_drained", sb.size(), 0);
        chk("bus_drained", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/line_fill_unit.md
Name: line_fill_unit

Overview:
- Bus-side partner of the L1 cache. Accepts one block-level read or write request from the cache and runs the system-bus transaction.
- Read: issues the address, collects the 8 response beats into a 64-byte line, acks each beat, then returns the assembled line.
- Write: sends the address beat, then streams 8 data beats.
- Sits between the cache and the system bus. It owns the bus_* wires so that the cache only handles a line-granular request/response.

Parameters:
ADDR_WIDTH, 64, address width
BUS_DATA_WIDTH, 64, bus beat width in bits
BUS_TAG_WIDTH, 13, bus tag width
LINE_BYTES, 64, cache block size; BEATS = LINE_BYTES*8/BUS_DATA_WIDTH = 8
TAG_READ, 13'h1100, tag driven on read address beat and expected on read response beats
TAG_WRITE, 13'h0100, tag driven on write address and data beats
TIMEOUT, 1024, cycles before abort (FILL_TIMEOUT_EN only)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  synchronous, active-low reset (0 = reset)
req_valid  in  1  cache requests a transaction
req_ready  out  1  unit can accept a request
req_write  in  1  1 = line write-back, 0 = line fill
req_addr  in  ADDR_WIDTH  byte address; low log2(LINE_BYTES) bits ignored
req_wdata  in  LINE_BYTES*8  write line, beat i = bits [64i+63:64i]
resp_valid  out  1  one-cycle pulse, transaction complete
resp_write  out  1  kind of completed transaction
resp_addr  out  ADDR_WIDTH  line-aligned address of completed transaction
resp_line  out  LINE_BYTES*8  assembled read line (write: holds last read line)
resp_err  out  1  one-cycle pulse, transaction aborted
busy  out  1  state != IDLE
bus_reqcyc  out  1  request beat valid
bus_reqack  in  1  bus accepted address beat
bus_req  out  BUS_DATA_WIDTH  address or write-data beat
bus_reqtag  out  BUS_TAG_WIDTH  request tag
bus_respcyc  in  1  response beat valid
bus_respack  out  1  response beat consumed
bus_resp  in  BUS_DATA_WIDTH  response beat
bus_resptag  in  BUS_TAG_WIDTH  response tag

Behaviour:
- Reset (reset==0 at posedge): state IDLE, beat counter 0. All outputs 0 except req_ready=1. resp_line=0.
- Reset mid-transaction aborts it; partial line discarded; no resp_valid or resp_err.
- req_ready = (state==IDLE). Request accepted on posedge with req_valid && req_ready. Captured: req_addr with low 6 bits zeroed, req_write, req_wdata.
- FSM states: IDLE, ADDR, WDATA, RDATA, DONE.
- IDLE -> ADDR on accept.
- ADDR: bus_reqcyc=1, bus_req=aligned address, bus_reqtag=TAG_READ or TAG_WRITE. Held stable until the posedge with bus_reqack=1, then -> WDATA (write) or RDATA (read).
- WDATA: bus_reqcyc=1, bus_reqtag=TAG_WRITE, bus_req=beat[cnt]. One beat per cycle, cnt 0..7, no per-beat ack. After beat 7 -> DONE.
- RDATA: bus_respack = bus_respcyc && (bus_resptag==TAG_READ), combinational.
  - Each acked beat is written to line bits [64*cnt+63:64*cnt]; cnt increments.
  - Beats with any other tag are not acked and not stored.
  - Idle cycles between beats are allowed. After beat 7 is acked -> DONE.
- DONE: resp_valid=1 for exactly one cycle with resp_addr, resp_write and resp_line (reads); then -> IDLE.
- resp_line/resp_addr/resp_write hold their values until the next DONE.
- Read latency: accept at cycle 0; ADDR at cycle 1. With reqack at cycle 1 and beats at cycles 2-9, resp_valid is at cycle 10.
- Write latency: accept at cycle 0, reqack at cycle 1, data beats at cycles 2-9, resp_valid at cycle 10.
- bus_reqcyc=0 outside ADDR/WDATA. bus_respack=0 outside RDATA.
- A request held during DONE is not accepted; it is accepted in the following IDLE cycle. Back-to-back minimum: one IDLE cycle between transactions.
- Beat counter is 3 bits; wraps to 0 on the final beat.

Optional Feature:
- Macro: FILL_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entering ADDR/RDATA and on every acked beat; otherwise it increments in ADDR and RDATA.
  - When it reaches TIMEOUT: resp_err pulses one cycle, resp_valid stays 0, partial line is discarded, FSM -> IDLE.
- When undefined: no counter; the FSM waits indefinitely; resp_err tied 0.

Test Plan:
- Read addr 0x1043 -> bus_req=0x1040, tag 0x1100. Reqack next cycle; beats 0x0..0x7 on consecutive cycles -> resp_valid at cycle 10, resp_line beat i = i, resp_addr=0x1040.
- Write addr 0x2000, wdata beat i = 0xA0+i, reqack delayed 3 cycles -> address held stable 4 cycles, tag 0x0100. Then beats 0xA0..0xA7 on 8 consecutive cycles, then resp_valid with resp_write=1.
- Read with beat gaps (beats at cycles 2,5,6,9,10,11,14,15) plus one beat tagged 0x0100 mid-stream -> stray beat not acked; 8 tagged beats stored in order.
- reset=0 asserted during RDATA after 4 beats -> next cycle req_ready=1, bus_respack=0, no resp_valid. A following read completes with correct data.
- req_valid held high continuously -> requests accepted only in IDLE; resp_valid pulses exactly once per transaction.
- FILL_TIMEOUT_EN, TIMEOUT=16, no reqack -> resp_err pulse 16 cycles after entering ADDR, then req_ready=1.
